rob_unit: RTL and testbench
===========================

ROB_UNIT -- requirements
Module: rob_unit

Interface
REQ-001 SHALL have parameter ROB_SIZE, default 8: number of entries, power of two.
REQ-002 SHALL have parameter ROB_BIT, default 3: log2(ROB_SIZE), the entry tag width.
REQ-003 SHALL have port clk_in, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst_in, input, 1 bit: asynchronous, active-low reset (0 = reset).
REQ-005 SHALL have port rdy_in, input, 1 bit: when low, all state is frozen.
REQ-006 SHALL have port issue_valid, input, 1 bit: the decoder allocates one entry.
REQ-007 SHALL have port issue_kind, input, 2 bits: 00 = reg-write, 01 = branch, 10 = store.
REQ-008 SHALL have port issue_rd, input, 5 bits: destination register.
REQ-009 SHALL have port issue_pred_pc, input, 32 bits: predicted next PC, used for branches only.
REQ-010 SHALL have port issue_rob_entry, output, ROB_BIT bits: tag the next issue receives (combinational tail).
REQ-011 SHALL have port is_full, output, 1 bit: combinational, high when count == ROB_SIZE.
REQ-012 SHALL have port rs_ready, input, 1 bit: reservation-station result broadcast valid.
REQ-013 SHALL have inputs rs_rob_entry (ROB_BIT bits), rs_value (32 bits) and next_pc (32 bits): result tag, result value and actual next PC.
REQ-014 SHALL have port lsb_ready, input, 1 bit, with inputs lsb_rob_entry (ROB_BIT bits) and lsb_value (32 bits): load/store completion broadcast.
REQ-015 SHALL have inputs q1_entry and q2_entry (ROB_BIT bits each): operand query tags.
REQ-016 SHALL have outputs q1_ready, q1_value, q2_ready and q2_value: combinational query results.
REQ-017 SHALL have outputs commit_valid (1 bit), commit_rd (5 bits), commit_value (32 bits) and commit_rob_entry (ROB_BIT bits): registered one-cycle register-file write.
REQ-018 SHALL have port commit_store, output, 1 bit: registered one-cycle pulse permitting the LSB to perform the head store.
REQ-019 SHALL have port rob_clear_up, output, 1 bit: registered one-cycle flush pulse.
REQ-020 SHALL have port clear_pc, output, 32 bits: corrected PC, valid while rob_clear_up is high.

Function
REQ-021 SHALL store per entry: busy, ready, kind, rd, value, pred_pc, actual_pc; circular head/tail pointers wrap modulo ROB_SIZE; count ranges 0..ROB_SIZE.
REQ-022 SHALL, on issue_valid && !is_full, write the entry at tail with busy=1 and ready=0, then advance tail; issue while full is ignored.
REQ-023 SHALL, on rs_ready, set ready=1 for busy entry rs_rob_entry and latch rs_value and next_pc; lsb_ready does the same with lsb_value. Both may hit different entries in the same cycle; a broadcast to a non-busy entry is ignored.
REQ-024 SHALL drive qN_ready=1 when entry qN is busy and ready, with qN_value = stored value. SHALL also forward a same-cycle rs/lsb broadcast that matches qN (ready=1, broadcast value).
REQ-025 SHALL commit at most one entry per cycle: only the head, only when busy and ready; commit frees the head and advances head; latency is 1 cycle from the ready edge to commit outputs.
REQ-026 SHALL, on a reg-write commit, pulse commit_valid with rd, value and tag; rd == 0 still commits, and the regfile ignores it.
REQ-027 SHALL, on a store commit, pulse commit_store; commit_valid stays 0.
REQ-028 SHALL, on a branch commit with actual_pc == pred_pc, retire without further effect.
REQ-029 SHALL, on a branch commit with actual_pc != pred_pc: pulse rob_clear_up with clear_pc = actual_pc; at the same edge clear all busy bits, set head = tail = count = 0, and ignore any issue in that cycle.
REQ-030 SHALL, for an issue and a commit in the same cycle, change count by 0; is_full is evaluated from the pre-edge count, so issue is refused when full even if a commit occurs.
REQ-031 SHALL default every one-cycle pulse output to 0 on each cycle without an event.
REQ-032 SHALL, with rdy_in low, hold all state and drive commit_valid, commit_store and rob_clear_up to 0.

Reset
REQ-033 SHALL, while rst_in == 0, immediately clear all busy/ready bits, set head = tail = count = 0, and drive commit_valid, commit_store, rob_clear_up and clear_pc to 0, independent of the clock.
REQ-034 SHALL resume normal operation on the first rising edge after rst_in returns to 1; entries in flight mid-operation are discarded.

Verification
REQ-035 Issue reg-write rd=5 (tag 0), then rs_ready with tag 0 and value 0x1234 -> next cycle commit_valid=1, rd=5, value 0x1234; is_full=0.
REQ-036 Issue 8 entries with no broadcasts -> is_full=1 and the 9th issue is ignored; commit tag 0 while issuing -> entry refused that cycle, accepted the next cycle at tag 0 (wrap).
REQ-037 Broadcast tag 2 ready before tag 0 -> no commit until tag 0 is ready, then tags 0, 1, 2 commit in order on consecutive cycles.
REQ-038 Branch with pred 0x100, actual 0x200, at head -> rob_clear_up=1 and clear_pc=0x200 for one cycle; afterwards count=0 and issue_rob_entry=0.
REQ-039 Same-cycle rs_ready tag 3 = 0xAB with q1_entry=3 -> q1_ready=1, q1_value=0xAB combinationally.
REQ-040 Drop rst_in to 0 mid-stream with 4 entries busy -> outputs clear without a clock edge; after release the first issue receives tag 0.

Source files
------------

// File: rtl/rob_unit.sv
// rtl/rob_unit.sv - reorder buffer with in-order commit and branch-mispredict flush
//
// Purpose: tracks up to ROB_SIZE in-flight instructions in a circular buffer,
// collects results from the reservation-station and load/store broadcasts,
// answers operand queries, and retires the head entry in program order.
//
// Ports:
//   clk_in, rst_in (async, active-low), rdy_in (low freezes all state)
//   issue_*          : allocation from the decoder; issue_rob_entry = next tag
//   is_full          : count == ROB_SIZE
//   rs_* / next_pc   : reservation-station result broadcast
//   lsb_*            : load/store completion broadcast
//   q1_* / q2_*      : combinational operand lookup with same-cycle forwarding
//   commit_*         : registered one-cycle retire outputs
//   rob_clear_up     : registered one-cycle flush pulse, clear_pc = redirect PC
module rob_unit #(
   parameter int ROB_SIZE = 8,
   parameter int ROB_BIT  = 3
) (
   input  logic               clk_in,
   input  logic               rst_in,
   input  logic               rdy_in,
   input  logic               issue_valid,
   input  logic [1:0]         issue_kind,
   input  logic [4:0]         issue_rd,
   input  logic [31:0]        issue_pred_pc,
   output logic [ROB_BIT-1:0] issue_rob_entry,
   output logic               is_full,
   input  logic               rs_ready,
   input  logic [ROB_BIT-1:0] rs_rob_entry,
   input  logic [31:0]        rs_value,
   input  logic [31:0]        next_pc,
   input  logic               lsb_ready,
   input  logic [ROB_BIT-1:0] lsb_rob_entry,
   input  logic [31:0]        lsb_value,
   input  logic [ROB_BIT-1:0] q1_entry,
   input  logic [ROB_BIT-1:0] q2_entry,
   output logic               q1_ready,
   output logic [31:0]        q1_value,
   output logic               q2_ready,
   output logic [31:0]        q2_value,
   output logic               commit_valid,
   output logic [4:0]         commit_rd,
   output logic [31:0]        commit_value,
   output logic [ROB_BIT-1:0] commit_rob_entry,
   output logic               commit_store,
   output logic               rob_clear_up,
   output logic [31:0]        clear_pc
);

   localparam logic [1:0]       KIND_REG = 2'b00;
   localparam logic [1:0]       KIND_BR  = 2'b01;
   localparam logic [1:0]       KIND_ST  = 2'b10;
   localparam logic [ROB_BIT:0] FULL_CNT = (ROB_BIT+1)'(ROB_SIZE);

   logic [ROB_SIZE-1:0] busy_q, busy_d, ready_q, ready_d;
   logic [1:0]          kind_q      [ROB_SIZE];
   logic [1:0]          kind_d      [ROB_SIZE];
   logic [4:0]          rd_q        [ROB_SIZE];
   logic [4:0]          rd_d        [ROB_SIZE];
   logic [31:0]         value_q     [ROB_SIZE];
   logic [31:0]         value_d     [ROB_SIZE];
   logic [31:0]         pred_pc_q   [ROB_SIZE];
   logic [31:0]         pred_pc_d   [ROB_SIZE];
   logic [31:0]         actual_pc_q [ROB_SIZE];
   logic [31:0]         actual_pc_d [ROB_SIZE];

   logic [ROB_BIT-1:0]  head_q, head_d, tail_q, tail_d;
   logic [ROB_BIT:0]    count_q, count_d;

   logic                commit_valid_q, commit_valid_d;
   logic [4:0]          commit_rd_q, commit_rd_d;
   logic [31:0]         commit_value_q, commit_value_d;
   logic [ROB_BIT-1:0]  commit_tag_q, commit_tag_d;
   logic                commit_store_q, commit_store_d;
   logic                clear_up_q, clear_up_d;
   logic [31:0]         clear_pc_q, clear_pc_d;

   logic                do_commit, do_issue, mispredict;

   assign is_full          = (count_q == FULL_CNT);
   assign issue_rob_entry  = tail_q;
   assign commit_valid     = commit_valid_q;
   assign commit_rd        = commit_rd_q;
   assign commit_value     = commit_value_q;
   assign commit_rob_entry = commit_tag_q;
   assign commit_store     = commit_store_q;
   assign rob_clear_up     = clear_up_q;
   assign clear_pc         = clear_pc_q;

   // Operand lookup: stored result, overridden by a broadcast landing this cycle.
   always_comb begin
      q1_ready = busy_q[q1_entry] && ready_q[q1_entry];
      q1_value = value_q[q1_entry];
      q2_ready = busy_q[q2_entry] && ready_q[q2_entry];
      q2_value = value_q[q2_entry];
      if (busy_q[q1_entry] && rs_ready && rs_rob_entry == q1_entry) begin
         q1_ready = 1'b1;
         q1_value = rs_value;
      end
      if (busy_q[q1_entry] && lsb_ready && lsb_rob_entry == q1_entry) begin
         q1_ready = 1'b1;
         q1_value = lsb_value;
      end
      if (busy_q[q2_entry] && rs_ready && rs_rob_entry == q2_entry) begin
         q2_ready = 1'b1;
         q2_value = rs_value;
      end
      if (busy_q[q2_entry] && lsb_ready && lsb_rob_entry == q2_entry) begin
         q2_ready = 1'b1;
         q2_value = lsb_value;
      end
   end

   always_comb begin
      busy_d         = busy_q;
      ready_d        = ready_q;
      kind_d         = kind_q;
      rd_d           = rd_q;
      value_d        = value_q;
      pred_pc_d      = pred_pc_q;
      actual_pc_d    = actual_pc_q;
      head_d         = head_q;
      tail_d         = tail_q;
      count_d        = count_q;
      commit_valid_d = 1'b0;
      commit_store_d = 1'b0;
      clear_up_d     = 1'b0;
      clear_pc_d     = '0;
      commit_rd_d    = commit_rd_q;
      commit_value_d = commit_value_q;
      commit_tag_d   = commit_tag_q;
      do_commit      = 1'b0;
      do_issue       = 1'b0;
      mispredict     = 1'b0;

      if (rdy_in) begin
         // Commit decisions use pre-edge state, so a result becomes visible
         // on the commit outputs one cycle after its ready bit is set.
         do_commit  = busy_q[head_q] && ready_q[head_q];
         mispredict = do_commit && (kind_q[head_q] == KIND_BR) &&
                      (actual_pc_q[head_q] != pred_pc_q[head_q]);
         do_issue   = issue_valid && !is_full && !mispredict;

         if (mispredict) begin
            busy_d     = '0;
            ready_d    = '0;
            head_d     = '0;
            tail_d     = '0;
            count_d    = '0;
            clear_up_d = 1'b1;
            clear_pc_d = actual_pc_q[head_q];
         end else begin
            if (rs_ready && busy_q[rs_rob_entry]) begin
               ready_d[rs_rob_entry]     = 1'b1;
               value_d[rs_rob_entry]     = rs_value;
               actual_pc_d[rs_rob_entry] = next_pc;
            end
            if (lsb_ready && busy_q[lsb_rob_entry]) begin
               ready_d[lsb_rob_entry] = 1'b1;
               value_d[lsb_rob_entry] = lsb_value;
            end
            if (do_commit) begin
               busy_d[head_q]  = 1'b0;
               ready_d[head_q] = 1'b0;
               head_d          = head_q + ROB_BIT'(1);
               if (kind_q[head_q] == KIND_REG) begin
                  commit_valid_d = 1'b1;
                  commit_rd_d    = rd_q[head_q];
                  commit_value_d = value_q[head_q];
                  commit_tag_d   = head_q;
               end else if (kind_q[head_q] == KIND_ST) begin
                  commit_store_d = 1'b1;
               end
            end
            if (do_issue) begin
               busy_d[tail_q]      = 1'b1;
               ready_d[tail_q]     = 1'b0;
               kind_d[tail_q]      = issue_kind;
               rd_d[tail_q]        = issue_rd;
               value_d[tail_q]     = '0;
               pred_pc_d[tail_q]   = issue_pred_pc;
               // An entry never resolved by the RS retires as correctly predicted.
               actual_pc_d[tail_q] = issue_pred_pc;
               tail_d              = tail_q + ROB_BIT'(1);
            end
            count_d = count_q + (ROB_BIT+1)'(do_issue) - (ROB_BIT+1)'(do_commit);
         end
      end
   end

   always_ff @(posedge clk_in or negedge rst_in) begin
      if (!rst_in) begin
         busy_q         <= '0;
         ready_q        <= '0;
         head_q         <= '0;
         tail_q         <= '0;
         count_q        <= '0;
         commit_valid_q <= 1'b0;
         commit_rd_q    <= '0;
         commit_value_q <= '0;
         commit_tag_q   <= '0;
         commit_store_q <= 1'b0;
         clear_up_q     <= 1'b0;
         clear_pc_q     <= '0;
         for (int i = 0; i < ROB_SIZE; i++) begin
            kind_q[i]      <= '0;
            rd_q[i]        <= '0;
            value_q[i]     <= '0;
            pred_pc_q[i]   <= '0;
            actual_pc_q[i] <= '0;
         end
      end else begin
         busy_q         <= busy_d;
         ready_q        <= ready_d;
         kind_q         <= kind_d;
         rd_q           <= rd_d;
         value_q        <= value_d;
         pred_pc_q      <= pred_pc_d;
         actual_pc_q    <= actual_pc_d;
         head_q         <= head_d;
         tail_q         <= tail_d;
         count_q        <= count_d;
         commit_valid_q <= commit_valid_d;
         commit_rd_q    <= commit_rd_d;
         commit_value_q <= commit_value_d;
         commit_tag_q   <= commit_tag_d;
         commit_store_q <= commit_store_d;
         clear_up_q     <= clear_up_d;
         clear_pc_q     <= clear_pc_d;
      end
   end

endmodule

// File: tb/tb_rob_unit.sv
// tb/tb_rob_unit.sv - directed and randomized checks of rob_unit against a queue model
module tb_rob_unit;

   localparam int RS = 8;

   logic        clk_in = 1'b0;
   logic        rst_in = 1'b1;
   logic        rdy_in = 1'b1;
   logic        issue_valid = 1'b0;
   logic [1:0]  issue_kind = '0;
   logic [4:0]  issue_rd = '0;
   logic [31:0] issue_pred_pc = '0;
   logic [2:0]  issue_rob_entry;
   logic        is_full;
   logic        rs_ready = 1'b0;
   logic [2:0]  rs_rob_entry = '0;
   logic [31:0] rs_value = '0;
   logic [31:0] next_pc = '0;
   logic        lsb_ready = 1'b0;
   logic [2:0]  lsb_rob_entry = '0;
   logic [31:0] lsb_value = '0;
   logic [2:0]  q1_entry = '0;
   logic [2:0]  q2_entry = '0;
   logic        q1_ready, q2_ready;
   logic [31:0] q1_value, q2_value;
   logic        commit_valid;
   logic [4:0]  commit_rd;
   logic [31:0] commit_value;
   logic [2:0]  commit_rob_entry;
   logic        commit_store;
   logic        rob_clear_up;
   logic [31:0] clear_pc;

   rob_unit #(.ROB_SIZE(8), .ROB_BIT(3)) dut (
      .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in),
      .issue_valid(issue_valid), .issue_kind(issue_kind), .issue_rd(issue_rd),
      .issue_pred_pc(issue_pred_pc), .issue_rob_entry(issue_rob_entry), .is_full(is_full),
      .rs_ready(rs_ready), .rs_rob_entry(rs_rob_entry), .rs_value(rs_value), .next_pc(next_pc),
      .lsb_ready(lsb_ready), .lsb_rob_entry(lsb_rob_entry), .lsb_value(lsb_value),
      .q1_entry(q1_entry), .q2_entry(q2_entry),
      .q1_ready(q1_ready), .q1_value(q1_value), .q2_ready(q2_ready), .q2_value(q2_value),
      .commit_valid(commit_valid), .commit_rd(commit_rd), .commit_value(commit_value),
      .commit_rob_entry(commit_rob_entry), .commit_store(commit_store),
      .rob_clear_up(rob_clear_up), .clear_pc(clear_pc)
   );

   always #5 clk_in = ~clk_in;

   int tests = 0;
   int fails = 0;

   // Reference model: in-flight instructions in program order, oldest first.
   typedef struct {
      logic [1:0]  kind;
      logic [4:0]  rd;
      logic        rdy;
      logic [31:0] val;
      logic [31:0] pred;
      logic [31:0] act;
      int          tag;
   } ent_t;

   ent_t        mq[$];
   int          m_tail = 0;
   logic        e_cv, e_cs, e_cu;
   logic [4:0]  e_rd;
   logic [31:0] e_val, e_pc;
   int          e_tag;

   task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", name, obs, exp);
      end
   endtask

   function automatic void m_query(input logic [2:0] t, output logic r, output logic [31:0] v);
      r = 1'b0;
      v = '0;
      foreach (mq[i]) begin
         if (mq[i].tag == int'(t)) begin
            if (mq[i].rdy) begin r = 1'b1; v = mq[i].val; end
            if (rs_ready && rs_rob_entry == t) begin r = 1'b1; v = rs_value; end
            if (lsb_ready && lsb_rob_entry == t) begin r = 1'b1; v = lsb_value; end
         end
      end
   endfunction

   function automatic void m_reset();
      mq.delete();
      m_tail = 0;
   endfunction

   // Advance the model across one rising edge using the current inputs.
   function automatic void m_edge();
      logic full;
      logic commit;
      logic flush;
      ent_t e;
      e_cv = 1'b0; e_cs = 1'b0; e_cu = 1'b0;
      if (!rdy_in) return;
      full   = (mq.size() == RS);
      commit = (mq.size() > 0) && mq[0].rdy;
      flush  = 1'b0;
      if (commit) begin
         case (mq[0].kind)
            2'b00: begin e_cv = 1'b1; e_rd = mq[0].rd; e_val = mq[0].val; e_tag = mq[0].tag; end
            2'b10: e_cs = 1'b1;
            2'b01: if (mq[0].act != mq[0].pred) begin
                      flush = 1'b1; e_cu = 1'b1; e_pc = mq[0].act;
                   end
            default: ;
         endcase
      end
      if (flush) begin
         m_reset();
         return;
      end
      for (int i = 0; i < mq.size(); i++) begin
         if (rs_ready && mq[i].tag == int'(rs_rob_entry)) begin
            mq[i].rdy = 1'b1; mq[i].val = rs_value; mq[i].act = next_pc;
         end
         if (lsb_ready && mq[i].tag == int'(lsb_rob_entry)) begin
            mq[i].rdy = 1'b1; mq[i].val = lsb_value;
         end
      end
      if (commit) void'(mq.pop_front());
      if (issue_valid && !full) begin
         e.kind = issue_kind; e.rd = issue_rd; e.rdy = 1'b0; e.val = '0;
         e.pred = issue_pred_pc; e.act = issue_pred_pc; e.tag = m_tail;
         mq.push_back(e);
         m_tail = (m_tail + 1) % RS;
      end
   endfunction

   task automatic check_comb();
      logic        r;
      logic [31:0] v;
      chk("is_full", 32'(is_full), 32'(mq.size() == RS));
      chk("issue_tag", 32'(issue_rob_entry), 32'(m_tail));
      m_query(q1_entry, r, v);
      chk("q1_ready", 32'(q1_ready), 32'(r));
      if (r) chk("q1_value", q1_value, v);
      m_query(q2_entry, r, v);
      chk("q2_ready", 32'(q2_ready), 32'(r));
      if (r) chk("q2_value", q2_value, v);
   endtask

   // One clock: check combinational outputs, step model, clock, check registered outputs.
   task automatic cyc();
      #1;
      check_comb();
      m_edge();
      @(posedge clk_in);
      #1;
      chk("commit_valid", 32'(commit_valid), 32'(e_cv));
      if (e_cv) begin
         chk("commit_rd", 32'(commit_rd), 32'(e_rd));
         chk("commit_value", commit_value, e_val);
         chk("commit_tag", 32'(commit_rob_entry), 32'(e_tag));
      end
      chk("commit_store", 32'(commit_store), 32'(e_cs));
      chk("rob_clear_up", 32'(rob_clear_up), 32'(e_cu));
      if (e_cu) chk("clear_pc", clear_pc, e_pc);
      issue_valid = 1'b0;
      rs_ready    = 1'b0;
      lsb_ready   = 1'b0;
   endtask

   task automatic issue(input logic [1:0] kind, input logic [4:0] rd, input logic [31:0] pred);
      issue_valid = 1'b1; issue_kind = kind; issue_rd = rd; issue_pred_pc = pred;
      cyc();
   endtask

   task automatic do_reset();
      rst_in = 1'b0;
      #1;
      m_reset();
      chk("rst_commit_valid", 32'(commit_valid), 32'd0);
      chk("rst_commit_store", 32'(commit_store), 32'd0);
      chk("rst_clear_up", 32'(rob_clear_up), 32'd0);
      chk("rst_clear_pc", clear_pc, 32'd0);
      chk("rst_is_full", 32'(is_full), 32'd0);
      chk("rst_issue_tag", 32'(issue_rob_entry), 32'd0);
      @(posedge clk_in);
      #2;
      rst_in = 1'b1;
   endtask

   initial begin
      int          t;
      logic [31:0] np;
      #3;
      do_reset();

      // Basic reg-write issue, result, commit.
      issue(2'b00, 5'd5, 32'h0);
      rs_ready = 1'b1; rs_rob_entry = 3'd0; rs_value = 32'h1234; next_pc = 32'h0;
      cyc();
      cyc();
      chk("r35_cv", 32'(commit_valid), 32'd1);
      chk("r35_rd", 32'(commit_rd), 32'd5);
      chk("r35_val", commit_value, 32'h1234);
      chk("r35_full", 32'(is_full), 32'd0);

      // Fill, refuse when full even with a same-cycle commit, then wrap to tag 0.
      do_reset();
      for (int i = 0; i < RS; i++) issue(2'b00, 5'(i + 1), 32'h0);
      chk("r36_full", 32'(is_full), 32'd1);
      issue(2'b00, 5'd20, 32'h0);
      chk("r36_9th_tag", 32'(issue_rob_entry), 32'd0);
      rs_ready = 1'b1; rs_rob_entry = 3'd0; rs_value = 32'h77;
      cyc();
      issue(2'b00, 5'd9, 32'h0);
      chk("r36_commit", 32'(commit_valid), 32'd1);
      chk("r36_ctag", 32'(commit_rob_entry), 32'd0);
      chk("r36_refused", 32'(issue_rob_entry), 32'd0);
      chk("r36_notfull", 32'(is_full), 32'd0);
      issue(2'b00, 5'd9, 32'h0);
      chk("r36_wrap_tag", 32'(issue_rob_entry), 32'd1);
      chk("r36_refull", 32'(is_full), 32'd1);

      // Out-of-order completion, in-order retirement.
      do_reset();
      for (int i = 0; i < 3; i++) issue(2'b00, 5'(i + 1), 32'h0);
      rs_ready = 1'b1; rs_rob_entry = 3'd2; rs_value = 32'h22;
      cyc();
      cyc();
      chk("r37_hold", 32'(commit_valid), 32'd0);
      rs_ready = 1'b1; rs_rob_entry = 3'd0; rs_value = 32'h20;
      lsb_ready = 1'b1; lsb_rob_entry = 3'd1; lsb_value = 32'h21;
      cyc();
      for (int i = 0; i < 3; i++) begin
         cyc();
         chk("r37_cv", 32'(commit_valid), 32'd1);
         chk("r37_order", 32'(commit_rob_entry), 32'(i));
      end

      // Mispredicted branch flushes; issue in the flush cycle is dropped.
      do_reset();
      issue(2'b01, 5'd0, 32'h100);
      rs_ready = 1'b1; rs_rob_entry = 3'd0; next_pc = 32'h200;
      cyc();
      issue_valid = 1'b1; issue_kind = 2'b00; issue_rd = 5'd3;
      cyc();
      chk("r38_clear", 32'(rob_clear_up), 32'd1);
      chk("r38_pc", clear_pc, 32'h200);
      chk("r38_tag0", 32'(issue_rob_entry), 32'd0);
      cyc();
      chk("r38_pulse", 32'(rob_clear_up), 32'd0);
      // Correct branch retires silently; store pulses commit_store only.
      issue(2'b01, 5'd0, 32'h300);
      issue(2'b10, 5'd0, 32'h0);
      rs_ready = 1'b1; rs_rob_entry = 3'd0; next_pc = 32'h300;
      lsb_ready = 1'b1; lsb_rob_entry = 3'd1; lsb_value = 32'h5;
      cyc();
      cyc();
      chk("br_ok_noclear", 32'(rob_clear_up), 32'd0);
      cyc();
      chk("st_pulse", 32'(commit_store), 32'd1);
      chk("st_no_cv", 32'(commit_valid), 32'd0);

      // Same-cycle forwarding, then asynchronous reset mid-stream.
      do_reset();
      for (int i = 0; i < 4; i++) issue(2'b00, 5'(i + 1), 32'h0);
      rs_ready = 1'b1; rs_rob_entry = 3'd3; rs_value = 32'hAB;
      lsb_ready = 1'b1; lsb_rob_entry = 3'd0; lsb_value = 32'h55;
      q1_entry = 3'd3; q2_entry = 3'd0;
      #1;
      chk("r39_q1_ready", 32'(q1_ready), 32'd1);
      chk("r39_q1_value", q1_value, 32'hAB);
      chk("r39_q2_value", q2_value, 32'h55);
      cyc();
      issue(2'b00, 5'd7, 32'h0);
      chk("r40_pre_cv", 32'(commit_valid), 32'd1);
      rst_in = 1'b0;
      #1;
      m_reset();
      chk("r40_cv_async", 32'(commit_valid), 32'd0);
      chk("r40_tag_async", 32'(issue_rob_entry), 32'd0);
      chk("r40_q1_cleared", 32'(q1_ready), 32'd0);
      @(posedge clk_in);
      #2;
      rst_in = 1'b1;
      issue(2'b00, 5'd8, 32'h0);
      rs_ready = 1'b1; rs_rob_entry = 3'd0; rs_value = 32'h99;
      cyc();
      cyc();
      chk("r40_first_tag", 32'(commit_rob_entry), 32'd0);
      chk("r40_first_val", commit_value, 32'h99);

      // Randomized traffic against the model.
      do_reset();
      for (int n = 0; n < 400; n++) begin
         rdy_in        = ($urandom_range(0, 19) != 0);
         issue_valid   = ($urandom_range(0, 9) < 6);
         issue_kind    = 2'($urandom_range(0, 2));
         issue_rd      = 5'($urandom);
         issue_pred_pc = 32'($urandom_range(0, 3)) << 2;
         t             = $urandom_range(0, RS - 1);
         rs_ready      = ($urandom_range(0, 9) < 4);
         rs_rob_entry  = 3'(t);
         rs_value      = $urandom;
         np            = $urandom;
         foreach (mq[i])
            if (mq[i].tag == t && mq[i].kind == 2'b01)
               np = ($urandom_range(0, 3) != 0) ? mq[i].pred : mq[i].pred + 32'd4;
         next_pc       = np;
         lsb_ready     = ($urandom_range(0, 9) < 3);
         lsb_rob_entry = 3'((t + 1 + $urandom_range(0, RS - 2)) % RS);
         lsb_value     = $urandom;
         q1_entry      = 3'($urandom_range(0, RS - 1));
         q2_entry      = 3'($urandom_range(0, RS - 1));
         cyc();
      end
      rdy_in = 1'b1;

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
